// File: rtl/alu_sequencer.sv
// ALU operation sequencer: accepts one request at a time, drives one-hot
// controls to an external ALU for a per-opcode number of cycles, then
// captures the 64-bit result and pulses done.
module alu_sequencer #(
   parameter int MUL_WAIT = 2,
   parameter int DIV_WAIT = 4
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] a_in,
   input  logic [31:0] b_in,
   input  logic [63:0] alu_c,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [12:0] ctl,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] z_hi,
   output logic [31:0] z_lo
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd3;
   localparam logic [3:0] OP_LAST = 4'd12;

   logic [1:0] state;
   logic [3:0] cnt;
   logic [3:0] op_q;

   logic accept;
   logic illegal_op;
   logic div_zero;
   logic capture;

   // Number of EXEC cycles the ALU needs for a given opcode.
   function automatic logic [3:0] wait_count(input logic [3:0] o);
      if (o == OP_MUL)
         wait_count = 4'(MUL_WAIT);
      else if (o == OP_DIV)
         wait_count = 4'(DIV_WAIT);
      else
         wait_count = 4'd1;
   endfunction

   // Request decode: acceptance and the two error short-cuts straight to DONE.
   always_comb begin
      accept     = (state == IDLE) && start;
      illegal_op = (op > OP_LAST);
      div_zero   = (op == OP_DIV) && (b_in == 32'd0);
      capture    = (state == EXEC) && (cnt <= 4'd1);
   end

   // Control path: FSM, wait counter, latched opcode and error flag.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= IDLE;
         cnt   <= 4'd0;
         op_q  <= 4'd0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q <= op;
                  if (illegal_op || div_zero) begin
                     err   <= 1'b1;
                     state <= DONE;
                  end else begin
                     err   <= 1'b0;
                     cnt   <= wait_count(op);
                     state <= EXEC;
                  end
               end
            end
            EXEC: begin
               cnt <= cnt - 4'd1;
               if (capture)
                  state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Data path: operand latch on acceptance, result capture on the last EXEC edge.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         alu_a <= 32'd0;
         alu_b <= 32'd0;
         z_hi  <= 32'd0;
         z_lo  <= 32'd0;
      end else begin
         if (accept) begin
            alu_a <= a_in;
            alu_b <= b_in;
            // Divide-by-zero reports the dividend and an all-ones quotient.
            if (div_zero && !illegal_op) begin
               z_hi <= a_in;
               z_lo <= 32'hFFFF_FFFF;
            end
         end
         if (capture) begin
            z_hi <= alu_c[63:32];
            z_lo <= alu_c[31:0];
         end
      end
   end

   // Status and one-hot ALU controls, decoded from state so reset clears them at once.
   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
      ctl  = 13'd0;
      if (state == EXEC)
         ctl = 13'(13'd1 << op_q);
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU on alu_c.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [31:0] a_in = 32'd0;
   logic [31:0] b_in = 32'd0;
   logic [63:0] alu_c;
   logic [31:0] alu_a, alu_b, z_hi, z_lo;
   logic [12:0] ctl;
   logic        busy, done, err;

   int total = 0;
   int passed = 0;
   int fails = 0;
   int done_seen;

   alu_sequencer #(.MUL_WAIT(2), .DIV_WAIT(4)) dut (
      .clk(clk), .clr(clr), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
      .alu_c(alu_c), .alu_a(alu_a), .alu_b(alu_b), .ctl(ctl), .busy(busy),
      .done(done), .err(err), .z_hi(z_hi), .z_lo(z_lo)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: junk pattern when no supported control is active.
   always_comb begin
      case (ctl)
         13'h0001: alu_c = {32'd0, alu_a + alu_b};
         13'h0002: alu_c = {32'd0, alu_a - alu_b};
         13'h0004: alu_c = {32'd0, alu_a} * {32'd0, alu_b};
         13'h0008: alu_c = (alu_b == 0) ? 64'd0 : {alu_a % alu_b, alu_a / alu_b};
         default:  alu_c = 64'hBAD0_BAD0_BAD0_BAD0;
      endcase
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o; a_in = a; b_in = b; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      // Asynchronous reset
      #2 clr = 1'b0;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err",  64'(err),  64'd0);
      check("rst_ctl",  64'(ctl),  64'd0);
      check("rst_alu_a", 64'(alu_a), 64'd0);
      check("rst_z", {z_hi, z_lo}, 64'd0);
      step(); step();
      clr = 1'b1;
      step();

      // ADD 5+7
      request(4'd0, 32'd5, 32'd7);
      check("add_ctl", 64'(ctl), 64'h0001);
      check("add_busy", 64'(busy), 64'd1);
      check("add_done_early", 64'(done), 64'd0);
      check("add_alu_a", 64'(alu_a), 64'd5);
      step();
      check("add_done", 64'(done), 64'd1);
      check("add_ctl_done", 64'(ctl), 64'd0);
      check("add_z", {z_hi, z_lo}, 64'd12);
      check("add_err", 64'(err), 64'd0);
      step();
      check("add_idle_done", 64'(done), 64'd0);
      check("add_idle_busy", 64'(busy), 64'd0);

      // SUB 5-7, upper half captured as supplied
      request(4'd1, 32'd5, 32'd7);
      step();
      check("sub_done", 64'(done), 64'd1);
      check("sub_z", {z_hi, z_lo}, 64'h0000_0000_FFFF_FFFE);
      step();

      // MUL 0x10000 * 0x10000, two EXEC cycles
      request(4'd2, 32'h0001_0000, 32'h0001_0000);
      check("mul_ctl1", 64'(ctl), 64'h0004);
      step();
      check("mul_ctl2", 64'(ctl), 64'h0004);
      check("mul_done_early", 64'(done), 64'd0);
      step();
      check("mul_done", 64'(done), 64'd1);
      check("mul_ctl_done", 64'(ctl), 64'd0);
      check("mul_z_hi", 64'(z_hi), 64'd1);
      check("mul_z_lo", 64'(z_lo), 64'd0);
      step();

      // DIV by zero: straight to DONE
      request(4'd3, 32'd9, 32'd0);
      check("dz_done", 64'(done), 64'd1);
      check("dz_err", 64'(err), 64'd1);
      check("dz_ctl", 64'(ctl), 64'd0);
      check("dz_z", {z_hi, z_lo}, 64'h0000_0009_FFFF_FFFF);
      step();
      check("dz_idle_done", 64'(done), 64'd0);
      check("dz_err_hold", 64'(err), 64'd1);

      // Illegal opcode 14: error, result untouched
      request(4'd14, 32'd1, 32'd2);
      check("ill_done", 64'(done), 64'd1);
      check("ill_err", 64'(err), 64'd1);
      check("ill_ctl", 64'(ctl), 64'd0);
      check("ill_z", {z_hi, z_lo}, 64'h0000_0009_FFFF_FFFF);
      step();

      // DIV 100/7 with an ignored ADD request during EXEC
      request(4'd3, 32'd100, 32'd7);
      check("div_ctl1", 64'(ctl), 64'h0008);
      a_in = 32'd555; op = 4'd0; start = 1'b1;
      step();
      start = 1'b0;
      check("div_ctl2", 64'(ctl), 64'h0008);
      check("div_alu_a_hold", 64'(alu_a), 64'd100);
      done_seen = 0;
      for (int i = 0; i < 2; i++) begin
         step();
         if (done) done_seen++;
      end
      check("div_no_early_done", 64'(done_seen), 64'd0);
      step();
      check("div_done", 64'(done), 64'd1);
      check("div_err_clear", 64'(err), 64'd0);
      check("div_z", {z_hi, z_lo}, 64'h0000_0002_0000_000E);
      done_seen = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (done || busy) done_seen++;
      end
      check("div_no_queued", 64'(done_seen), 64'd0);

      // Reset during the 2nd EXEC cycle of a DIV
      request(4'd3, 32'd50, 32'd5);
      step();
      check("rdiv_ctl", 64'(ctl), 64'h0008);
      #2 clr = 1'b0;
      #1;
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_ctl", 64'(ctl), 64'd0);
      check("mid_rst_ops", {alu_a, alu_b}, 64'd0);
      check("mid_rst_z", {z_hi, z_lo}, 64'd0);
      check("mid_rst_err", 64'(err), 64'd0);
      done_seen = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (done) done_seen++;
      end
      check("mid_rst_no_done", 64'(done_seen), 64'd0);
      clr = 1'b1;

      // ADD right after reset release
      request(4'd0, 32'd3, 32'd4);
      check("post_add_ctl", 64'(ctl), 64'h0001);
      step();
      check("post_add_done", 64'(done), 64'd1);
      check("post_add_z", {z_hi, z_lo}, 64'd7);
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
